ysyx22041405_wbu_stage: RTL and testbench
=========================================

YSYX22041405_WBU_STAGE -- requirements
Module: ysyx22041405_wbu_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning datapath width (32 or 64).
REQ-002 SHALL have parameter RA_W, default 5, meaning register-address width.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state is rising-edge.
REQ-004 SHALL have port rst  input  1  meaning asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  meaning an upstream MEM-stage beat is present.
REQ-006 SHALL have port in_ready  output  1  meaning the stage accepts a beat this cycle.
REQ-007 SHALL have port in_pc  input  WIDTH  meaning the instruction PC.
REQ-008 SHALL have port in_alu_res  input  WIDTH  meaning the ALU result, which is also the load address.
REQ-009 SHALL have port in_dm_rdata  input  WIDTH  meaning the raw aligned memory word.
REQ-010 SHALL have port in_rd  input  RA_W  meaning the destination register.
REQ-011 SHALL have port in_rf_wen  input  1  meaning the instruction writes rd.
REQ-012 SHALL have port in_wb_sel  input  1  meaning the result source: 0 = ALU, 1 = memory.
REQ-013 SHALL have port in_wb_mask  input  8  meaning a byte-enable-style size code from the package.
REQ-014 SHALL have port in_sext  input  1  meaning sign-extend a load; 0 = zero-extend.
REQ-015 SHALL have port out_valid / out_ready  output / input  1 / 1  meaning the commit handshake toward the regfile/difftest.
REQ-016 SHALL have port rf_wen  output  1  meaning the regfile write strobe.
REQ-017 SHALL have port rf_waddr  output  RA_W  meaning the regfile write address.
REQ-018 SHALL have port rf_wdata  output  WIDTH  meaning the regfile write data.
REQ-019 SHALL have port commit_pc  output  WIDTH  meaning the PC of the committing beat.
REQ-020 SHALL have port fwd_valid  output  1  meaning the head entry will write a nonzero rd.
REQ-021 SHALL have port fwd_rd  output  RA_W  meaning the rd of the head entry.
REQ-022 SHALL have port fwd_data  output  WIDTH  meaning the write data of the head entry, for the EX bypass.

Function
REQ-023 SHALL hold beats in a 2-entry FIFO with states EMPTY, ONE and FULL, and in_ready SHALL equal (state != FULL).
REQ-024 SHALL accept a beat when in_valid && in_ready, and retire a beat when out_valid && out_ready.
- EMPTY: accept -> ONE.
- ONE: accept only -> FULL; retire only -> EMPTY; accept and retire together -> ONE.
- FULL: retire -> ONE; no accept is possible in FULL.
REQ-025 SHALL drive out_valid = (state != FULL ? state == ONE : 1), i.e. out_valid = (state != EMPTY); latency is one cycle from accept to out_valid, with no combinational in-to-out path.
REQ-026 SHALL compute result data at accept time and store it, so the head entry is never recomputed.
- Byte offset off = in_alu_res[log2(WIDTH/8)-1:0].
- The loaded field is in_dm_rdata >> (8*off), masked to the size in in_wb_mask.
REQ-027 SHALL sign-extend the loaded field from its MSB when in_sext = 1, and zero-extend it otherwise.
REQ-028 SHALL write the loaded data when in_wb_sel = 1 and in_alu_res unchanged when in_wb_sel = 0; the mask and in_sext are ignored for in_wb_sel = 0.
REQ-029 SHALL treat an undefined mask code as full width.
REQ-030 SHALL treat the DWORD code, when WIDTH = 32, as WORD.
REQ-031 SHALL set rf_wen = out_valid && out_ready && head.rf_wen && (head.rd != 0); writes to x0 are suppressed but still commit.
REQ-032 SHALL drive rf_waddr, rf_wdata and commit_pc from the head entry at all times; they are don't-care when out_valid = 0.
REQ-033 SHALL set fwd_valid = out_valid && head.rf_wen && (head.rd != 0), independent of out_ready.
REQ-034 SHALL hold the head entry stable while out_valid && !out_ready.

Reset
REQ-035 SHALL, on rst asserting at any time including mid-transfer, immediately force state to EMPTY, which gives in_ready = 1, out_valid = 0, rf_wen = 0 and fwd_valid = 0.
REQ-036 SHALL leave entry data unreset, but it SHALL never be visible while EMPTY.
REQ-037 SHALL resume accepting beats on the first rising edge after rst deasserts.

Structure
REQ-038 SHALL take MASK_BYTE = 8'h01, MASK_HALF = 8'h03, MASK_WORD = 8'h0F, MASK_DWORD = 8'hFF and the FIFO state encoding from the shared package ysyx22041405_pkg.
REQ-039 SHALL implement load alignment and extension as the combinational sub-module ysyx22041405_ld_ext (parameter WIDTH), instantiated once on the input path.

Verification
REQ-040 SHALL be verified for WIDTH = 32 by the following directed scenarios:
- Byte load, signed: dm_rdata = 32'h80FF7F01, addr = ...02, mask = BYTE, sext = 1, sel = 1 -> rf_wdata = 32'hFFFFFFFF one cycle later.
- Half load, unsigned: dm_rdata = 32'h80FF7F01, addr = ...02, mask = HALF, sext = 0 -> rf_wdata = 32'h000080FF.
- ALU result to x0: sel = 0, alu = 32'h1234, rd = 0, rf_wen = 1 -> out_valid = 1, rf_wen = 0, fwd_valid = 0.
- Backpressure: out_ready = 0 with 3 back-to-back beats -> in_ready falls after beat 2; beat 3 is held upstream; release commits beats 1, 2, 3 in order with no loss.
- Simultaneous accept and retire in ONE for 10 cycles -> state stays ONE and throughput is one beat per cycle.
- rst asserted while FULL -> out_valid = 0 and in_ready = 1 before the next edge; no rf_wen pulse.

Source files
------------

// File: rtl/ysyx22041405_pkg.sv
// Shared definitions for the write-back stage: load size codes and FIFO state encoding.
package ysyx22041405_pkg;

    localparam logic [7:0] MASK_BYTE  = 8'h01;
    localparam logic [7:0] MASK_HALF  = 8'h03;
    localparam logic [7:0] MASK_WORD  = 8'h0F;
    localparam logic [7:0] MASK_DWORD = 8'hFF;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } fifo_state_e;

endpackage

// File: rtl/ysyx22041405_ld_ext.sv
// Load alignment and sign/zero extension of a raw aligned memory word.
module ysyx22041405_ld_ext
    import ysyx22041405_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [$clog2(WIDTH/8)-1:0] off,
    input  logic [WIDTH-1:0]           rdata,
    input  logic [7:0]                 mask,
    input  logic                       sext,
    output logic [WIDTH-1:0]           ld_data_c
);

    localparam int unsigned OFF_W = $clog2(WIDTH/8);

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] keep;
    logic             sign;

    // Undefined codes and DWORD fall to full width, which is also WORD when WIDTH = 32.
    always_comb begin
        shifted   = rdata >> {off, 3'b000};
        keep      = '1;
        sign      = shifted[WIDTH-1];
        ld_data_c = '0;
        case (mask)
            MASK_BYTE: begin
                keep = WIDTH'(64'hFF);
                sign = shifted[7];
            end
            MASK_HALF: begin
                keep = WIDTH'(64'hFFFF);
                sign = shifted[15];
            end
            MASK_WORD: begin
                keep = WIDTH'(64'hFFFF_FFFF);
                sign = shifted[31];
            end
            default: begin
                keep = '1;
                sign = shifted[WIDTH-1];
            end
        endcase
        ld_data_c = (shifted & keep) | ((sext && sign) ? ~keep : '0);
    end

    logic unused_off_w;
    assign unused_off_w = ^OFF_W;

endmodule

// File: rtl/ysyx22041405_wbu_stage.sv
// Write-back stage: 2-entry skid FIFO holding precomputed results, committing to the regfile.
module ysyx22041405_wbu_stage
    import ysyx22041405_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned RA_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_pc,
    input  logic [WIDTH-1:0] in_alu_res,
    input  logic [WIDTH-1:0] in_dm_rdata,
    input  logic [RA_W-1:0]  in_rd,
    input  logic             in_rf_wen,
    input  logic             in_wb_sel,
    input  logic [7:0]       in_wb_mask,
    input  logic             in_sext,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             rf_wen,
    output logic [RA_W-1:0]  rf_waddr,
    output logic [WIDTH-1:0] rf_wdata,
    output logic [WIDTH-1:0] commit_pc,
    output logic             fwd_valid,
    output logic [RA_W-1:0]  fwd_rd,
    output logic [WIDTH-1:0] fwd_data
);

    localparam int unsigned OFF_W = $clog2(WIDTH/8);

    fifo_state_e state, state_nxt;

    logic             push;
    logic             pop;
    logic             wr_ptr;
    logic             rd_ptr;
    logic [WIDTH-1:0] ld_data_c;
    logic [WIDTH-1:0] wb_data_c;

    logic [WIDTH-1:0] pc_q   [2];
    logic [WIDTH-1:0] data_q [2];
    logic [RA_W-1:0]  rd_q   [2];
    logic             wen_q  [2];

    ysyx22041405_ld_ext #(
        .WIDTH (WIDTH)
    ) u_ld_ext (
        .off       (in_alu_res[OFF_W-1:0]),
        .rdata     (in_dm_rdata),
        .mask      (in_wb_mask),
        .sext      (in_sext),
        .ld_data_c (ld_data_c)
    );

    assign wb_data_c = in_wb_sel ? ld_data_c : in_alu_res;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (push) state_nxt = ST_ONE;
            ST_ONE: begin
                if (push && !pop)      state_nxt = ST_FULL;
                else if (pop && !push) state_nxt = ST_EMPTY;
            end
            ST_FULL:  if (pop) state_nxt = ST_ONE;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        rf_wen    = 1'b0;
        fwd_valid = 1'b0;
        rf_waddr  = rd_q[rd_ptr];
        rf_wdata  = data_q[rd_ptr];
        commit_pc = pc_q[rd_ptr];
        fwd_rd    = rd_q[rd_ptr];
        fwd_data  = data_q[rd_ptr];
        in_ready  = (state != ST_FULL);
        out_valid = (state != ST_EMPTY);
        fwd_valid = out_valid && wen_q[rd_ptr] && (rd_q[rd_ptr] != '0);
        rf_wen    = fwd_valid && out_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
        end
    end

    // Entry payload is not reset; EMPTY keeps it invisible.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[wr_ptr]   <= in_pc;
            data_q[wr_ptr] <= wb_data_c;
            rd_q[wr_ptr]   <= in_rd;
            wen_q[wr_ptr]  <= in_rf_wen;
        end
    end

endmodule

// File: tb/tb_ysyx22041405_wbu_stage.sv
// Directed self-checking bench for the write-back stage at WIDTH = 32.
module tb_ysyx22041405_wbu_stage;
    import ysyx22041405_pkg::*;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned RA_W  = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_pc;
    logic [WIDTH-1:0] in_alu_res;
    logic [WIDTH-1:0] in_dm_rdata;
    logic [RA_W-1:0]  in_rd;
    logic             in_rf_wen;
    logic             in_wb_sel;
    logic [7:0]       in_wb_mask;
    logic             in_sext;
    logic             out_valid;
    logic             out_ready;
    logic             rf_wen;
    logic [RA_W-1:0]  rf_waddr;
    logic [WIDTH-1:0] rf_wdata;
    logic [WIDTH-1:0] commit_pc;
    logic             fwd_valid;
    logic [RA_W-1:0]  fwd_rd;
    logic [WIDTH-1:0] fwd_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx22041405_wbu_stage #(.WIDTH(WIDTH), .RA_W(RA_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pc       (in_pc),
        .in_alu_res  (in_alu_res),
        .in_dm_rdata (in_dm_rdata),
        .in_rd       (in_rd),
        .in_rf_wen   (in_rf_wen),
        .in_wb_sel   (in_wb_sel),
        .in_wb_mask  (in_wb_mask),
        .in_sext     (in_sext),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .rf_wen      (rf_wen),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .commit_pc   (commit_pc),
        .fwd_valid   (fwd_valid),
        .fwd_rd      (fwd_rd),
        .fwd_data    (fwd_data)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_beat(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rdata,
                            input logic [4:0] rd, input logic wen, input logic sel,
                            input logic [7:0] mask, input logic sext);
        in_valid    = 1'b1;
        in_pc       = pc;
        in_alu_res  = alu;
        in_dm_rdata = rdata;
        in_rd       = rd;
        in_rf_wen   = wen;
        in_wb_sel   = sel;
        in_wb_mask  = mask;
        in_sext     = sext;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single-beat load/ALU vectors: addr, mask, sext, sel, alu, expected write data.
    typedef struct {
        logic [31:0] alu;
        logic [7:0]  mask;
        logic        sext;
        logic        sel;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [9];

    initial begin
        vecs[0] = '{32'h0000_1002, MASK_BYTE,  1'b1, 1'b1, 32'hFFFF_FFFF};
        vecs[1] = '{32'h0000_1002, MASK_HALF,  1'b0, 1'b1, 32'h0000_80FF};
        vecs[2] = '{32'h0000_1002, MASK_HALF,  1'b1, 1'b1, 32'hFFFF_80FF};
        vecs[3] = '{32'h0000_1000, MASK_HALF,  1'b1, 1'b1, 32'h0000_7F01};
        vecs[4] = '{32'h0000_1003, MASK_BYTE,  1'b0, 1'b1, 32'h0000_0080};
        vecs[5] = '{32'h0000_1001, MASK_BYTE,  1'b1, 1'b1, 32'h0000_007F};
        vecs[6] = '{32'h0000_1000, MASK_DWORD, 1'b0, 1'b1, 32'h80FF_7F01};
        vecs[7] = '{32'h0000_1000, 8'h07,      1'b1, 1'b1, 32'h80FF_7F01};
        vecs[8] = '{32'hABCD_0003, MASK_BYTE,  1'b1, 1'b0, 32'hABCD_0003};
    end

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        set_beat('0, '0, '0, '0, 1'b0, 1'b0, MASK_WORD, 1'b0);
        in_valid   = 1'b0;
        #1;
        check_eq("rst_in_ready",  64'(in_ready),  64'd1);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_rf_wen",    64'(rf_wen),    64'd0);
        check_eq("rst_fwd_valid", 64'(fwd_valid), 64'd0);
        step();
        step();
        rst = 1'b0;
        step();

        // Load/ALU data path, one beat at a time with one-cycle latency.
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            set_beat(32'h8000_0000 + 32'(i * 4), vecs[i].alu, 32'h80FF_7F01, 5'd7, 1'b1,
                     vecs[i].sel, vecs[i].mask, vecs[i].sext);
            #1;
            check_eq("lat_out_valid", 64'(out_valid), 64'd0);
            step();
            in_valid = 1'b0;
            #1;
            check_eq("vec_out_valid", 64'(out_valid), 64'd1);
            check_eq("vec_wdata", 64'(rf_wdata), 64'(vecs[i].exp));
            check_eq("vec_rf_wen", 64'(rf_wen), 64'd1);
            check_eq("vec_pc", 64'(commit_pc), 64'(32'h8000_0000 + 32'(i * 4)));
            step();
            check_eq("vec_drained", 64'(out_valid), 64'd0);
        end

        // ALU result to x0 commits without a regfile write.
        set_beat(32'h8000_0100, 32'h0000_1234, 32'h0, 5'd0, 1'b1, 1'b0, MASK_BYTE, 1'b1);
        step();
        in_valid = 1'b0;
        #1;
        check_eq("x0_out_valid", 64'(out_valid), 64'd1);
        check_eq("x0_rf_wen",    64'(rf_wen),    64'd0);
        check_eq("x0_fwd_valid", 64'(fwd_valid), 64'd0);
        check_eq("x0_wdata",     64'(rf_wdata),  64'h1234);
        step();

        // Backpressure with three back-to-back beats.
        out_ready = 1'b0;
        set_beat(32'h100, 32'hB1, '0, 5'd1, 1'b1, 1'b0, MASK_WORD, 1'b0);
        #1;
        check_eq("bp_rdy0", 64'(in_ready), 64'd1);
        step();
        set_beat(32'h104, 32'hB2, '0, 5'd2, 1'b1, 1'b0, MASK_WORD, 1'b0);
        #1;
        check_eq("bp_rdy1",   64'(in_ready),  64'd1);
        check_eq("bp_fwd1",   64'(fwd_valid), 64'd1);
        check_eq("bp_fwdrd1", 64'(fwd_rd),    64'd1);
        check_eq("bp_wen1",   64'(rf_wen),    64'd0);
        step();
        set_beat(32'h108, 32'hB3, '0, 5'd3, 1'b1, 1'b0, MASK_WORD, 1'b0);
        #1;
        check_eq("bp_rdy2",  64'(in_ready), 64'd0);
        check_eq("bp_hold2", 64'(rf_wdata), 64'hB1);
        step();
        check_eq("bp_rdy3",  64'(in_ready), 64'd0);
        check_eq("bp_hold3", 64'(fwd_data), 64'hB1);
        out_ready = 1'b1;
        #1;
        check_eq("bp_c1_wen",  64'(rf_wen),   64'd1);
        check_eq("bp_c1_data", 64'(rf_wdata), 64'hB1);
        check_eq("bp_c1_addr", 64'(rf_waddr), 64'd1);
        step();
        check_eq("bp_c2_rdy",  64'(in_ready), 64'd1);
        check_eq("bp_c2_data", 64'(rf_wdata), 64'hB2);
        check_eq("bp_c2_pc",   64'(commit_pc), 64'h104);
        step();
        in_valid = 1'b0;
        #1;
        check_eq("bp_c3_data", 64'(rf_wdata),  64'hB3);
        check_eq("bp_c3_pc",   64'(commit_pc), 64'h108);
        check_eq("bp_c3_wen",  64'(rf_wen),    64'd1);
        step();
        check_eq("bp_empty", 64'(out_valid), 64'd0);

        // Sustained accept and retire in ONE: one beat per cycle.
        set_beat(32'h200, 32'hC00, '0, 5'd4, 1'b1, 1'b0, MASK_WORD, 1'b0);
        step();
        for (int k = 1; k <= 10; k++) begin
            set_beat(32'h200 + 32'(k * 4), 32'hC00 + 32'(k), '0, 5'd4, 1'b1, 1'b0, MASK_WORD, 1'b0);
            #1;
            check_eq("tp_rdy",  64'(in_ready), 64'd1);
            check_eq("tp_data", 64'(rf_wdata), 64'(32'hC00 + 32'(k - 1)));
            check_eq("tp_wen",  64'(rf_wen),   64'd1);
            step();
        end
        in_valid = 1'b0;
        #1;
        check_eq("tp_last", 64'(rf_wdata), 64'hC0A);
        step();
        check_eq("tp_empty", 64'(out_valid), 64'd0);

        // Reset while FULL, asserted mid-cycle.
        out_ready = 1'b0;
        set_beat(32'h300, 32'hD1, '0, 5'd5, 1'b1, 1'b0, MASK_WORD, 1'b0);
        step();
        set_beat(32'h304, 32'hD2, '0, 5'd6, 1'b1, 1'b0, MASK_WORD, 1'b0);
        step();
        in_valid = 1'b0;
        check_eq("full_rdy", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        rst = 1'b1;
        #1;
        check_eq("rstf_out_valid", 64'(out_valid), 64'd0);
        check_eq("rstf_in_ready",  64'(in_ready),  64'd1);
        check_eq("rstf_rf_wen",    64'(rf_wen),    64'd0);
        check_eq("rstf_fwd_valid", 64'(fwd_valid), 64'd0);
        step();
        check_eq("rstf_hold_wen", 64'(rf_wen), 64'd0);
        rst = 1'b0;
        set_beat(32'h400, 32'hE1, '0, 5'd9, 1'b1, 1'b0, MASK_WORD, 1'b0);
        step();
        in_valid = 1'b0;
        #1;
        check_eq("resume_valid", 64'(out_valid), 64'd1);
        check_eq("resume_data",  64'(rf_wdata),  64'hE1);
        step();
        check_eq("resume_empty", 64'(out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
